// File: rtl/obj_func_pkg.sv
// Shared types for the obj_func host-side result collector.
package obj_func_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KICK    = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } collect_state_t;

    localparam int NUM_GRAD_DEFAULT = 10;

    // Read address spans f (0) plus one slot per gradient element.
    function automatic int addr_w(input int num_grad);
        return $clog2(num_grad + 1);
    endfunction

    localparam int ADDR_W = addr_w(NUM_GRAD_DEFAULT);

endpackage

// File: rtl/obj_result_collector.sv
// Host-side reader for obj_func: kicks a run, captures f and the gradient stream, serves reads.
// Optional COLLECT watchdog enabled by defining OBJ_COLLECT_TIMEOUT_EN.
module obj_result_collector
    import obj_func_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_GRAD    = NUM_GRAD_DEFAULT,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               op_objfunc,
    input  logic                               valid_objfuncf,
    input  logic [DATA_WIDTH-1:0]              result_objfuncf,
    input  logic                               valid_objgradf,
    input  logic [DATA_WIDTH-1:0]              result_objgradf,
    input  logic                               flagover_objgradf,
    output logic [$clog2(NUM_GRAD+1)-1:0]      grad_count,
    output logic                               err_overflow,
    output logic                               err_timeout,
    input  logic                               rd_en,
    input  logic [$clog2(NUM_GRAD+1)-1:0]      rd_addr,
    output logic                               rd_valid,
    output logic [DATA_WIDTH-1:0]              rd_data
);

    localparam int AW = addr_w(NUM_GRAD);

    collect_state_t state_q, state_nx;

    logic                  f_seen, grad_end, overflow_q, timeout_q;
    logic [AW-1:0]         count_q;
    logic                  accept, in_collect, full, complete, timeout_hit;
    logic [DATA_WIDTH-1:0] f_q;
    logic [DATA_WIDTH-1:0] grad_q [NUM_GRAD];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_vld_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    assign accept     = start && (state_q == IDLE || state_q == DONE);
    assign in_collect = (state_q == COLLECT);
    assign full       = (count_q == AW'(NUM_GRAD));
    // Completion looks at this cycle's strobes so f and flagover may land together in either order.
    assign complete   = in_collect && (f_seen || valid_objfuncf) && (grad_end || flagover_objgradf);

`ifdef OBJ_COLLECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            tmo_cnt <= '0;
        else if (!in_collect) tmo_cnt <= '0;
        else                 tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout_hit = in_collect && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE:    if (start) state_nx = KICK;
            KICK:    state_nx = COLLECT;
            COLLECT: if (complete || timeout_hit) state_nx = DONE;
            DONE:    if (start) state_nx = KICK;
            default: state_nx = IDLE;
        endcase
    end

    // Run bookkeeping is cleared on the accepted start so KICK already shows a fresh run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_seen     <= 1'b0;
            grad_end   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (accept) begin
            f_seen     <= 1'b0;
            grad_end   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (in_collect) begin
            if (valid_objfuncf)            f_seen     <= 1'b1;
            if (valid_objgradf && !full)   count_q    <= count_q + 1'b1;
            if (valid_objgradf && full)    overflow_q <= 1'b1;
            if (flagover_objgradf)         grad_end   <= 1'b1;
            if (timeout_hit && !complete)  timeout_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_collect && valid_objfuncf)          f_q            <= result_objfuncf;
        if (in_collect && valid_objgradf && !full) grad_q[count_q] <= result_objgradf;
    end

    always_comb begin
        rd_word = '0;
        if (!busy) begin
            if (rd_addr == '0)
                rd_word = f_q;
            else if (rd_addr <= AW'(NUM_GRAD) && rd_addr <= count_q)
                rd_word = grad_q[rd_addr - 1'b1];
        end
    end

    // read stage p1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            rd_vld_p1  <= rd_en;
            rd_data_p1 <= rd_en ? rd_word : '0;
        end
    end

    assign busy         = (state_q == KICK) || (state_q == COLLECT);
    assign done         = (state_q == DONE);
    assign op_objfunc   = (state_q == KICK);
    assign grad_count   = count_q;
    assign err_overflow = overflow_q;
    assign err_timeout  = timeout_q;
    assign rd_valid     = rd_vld_p1;
    assign rd_data      = rd_data_p1;

endmodule
